// File: rtl/rnn_accel.sv
// Q8.8 Elman RNN slave (4 in, 32 hidden, scalar dense out), one MAC per cycle; step 1154 cycles, dense 32.
// Writes outside LOAD/VALID are dropped. Optional macro RNN_HARDTANH_EN clamps activations to +/-1.0.
module rnn_accel (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_MAC, S_UPDATE, S_DENSE, S_VALID
  } state_t;

  state_t state_q, state_d;

  logic signed [15:0] x_q  [4];
  logic signed [15:0] w_q  [128];   // {row[1:0], col[4:0]}
  logic signed [15:0] r_q  [1024];  // {row[4:0], col[4:0]}
  logic signed [15:0] b_q  [32];
  logic signed [15:0] d_q  [32];
  logic signed [15:0] h_q  [32];
  logic signed [15:0] hn_q [32];
  logic signed [15:0] dense_b_q;
  logic signed [15:0] result_q;
  logic signed [39:0] acc_q, acc_d;
  logic        [5:0]  i_q, i_d;
  logic        [4:0]  j_q, j_d;
  logic        [31:0] data_out_q, data_out_d;

  logic               addr_ok, wr_ok, busy, valid;
  logic        [15:0] idx;
  logic        [7:0]  row, col;
  logic signed [15:0] wval;

  assign addr_ok = (addr[31:3] == 29'd0);
  assign wr_ok   = write && addr_ok && ((state_q == S_LOAD) || (state_q == S_VALID));
  assign idx     = data_in[31:16];
  assign row     = data_in[31:24];
  assign col     = data_in[23:16];
  assign wval    = $signed(data_in[15:0]);
  assign busy    = (state_q == S_START) || (state_q == S_MAC) ||
                   (state_q == S_UPDATE) || (state_q == S_DENSE);
  assign valid   = (state_q == S_VALID);
  assign data_out = data_out_q;

  function automatic logic signed [15:0] sat16(input logic signed [39:0] a,
                                               input logic signed [15:0] bias);
    logic signed [40:0] s;
    s = $signed({{9{a[39]}}, a[39:8]}) + $signed({{25{bias[15]}}, bias});
    if (s > 41'sd32767)       return 16'sh7FFF;
    else if (s < -41'sd32768) return 16'sh8000;
    else                      return $signed(s[15:0]);
  endfunction

  function automatic logic signed [15:0] act(input logic signed [15:0] z);
`ifdef RNN_HARDTANH_EN
    if (z > 16'sd256)  return 16'sd256;
    if (z < -16'sd256) return -16'sd256;
`endif
    return z;
  endfunction

  // Shared multiplier: i 0..3 walks x*W, i 4..35 walks h*R; dense reuses j as the k index.
  logic        [4:0]  hk;
  logic signed [15:0] op_a, op_b;
  logic signed [31:0] prod;
  logic signed [39:0] acc_sum;
  logic               first;

  always_comb begin
    hk    = 5'(i_q - 6'd4);
    op_a  = '0;
    op_b  = '0;
    first = (i_q == 6'd0);
    if (state_q == S_DENSE) begin
      op_a  = h_q[j_q];
      op_b  = d_q[j_q];
      first = (j_q == 5'd0);
    end else if (i_q < 6'd4) begin
      op_a = x_q[i_q[1:0]];
      op_b = w_q[{i_q[1:0], j_q}];
    end else begin
      op_a = h_q[hk];
      op_b = r_q[{hk, j_q}];
    end
  end

  assign prod    = op_a * op_b;
  assign acc_sum = (first ? 40'sd0 : acc_q) + $signed({{8{prod[31]}}, prod});

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    case (state_q)
      S_LOAD, S_VALID: begin
        if (wr_ok && addr[2:0] == 3'd0) begin
          state_d = S_START;
        end else if (wr_ok && addr[2:0] == 3'd7) begin
          state_d = S_DENSE;
          j_d     = '0;
        end
      end
      S_START: begin
        state_d = S_MAC;
        i_d     = '0;
        j_d     = '0;
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (i_q == 6'd35) begin
          i_d = '0;
          j_d = j_q + 5'd1;
          if (j_q == 5'd31) state_d = S_UPDATE;
        end else begin
          i_d = i_q + 6'd1;
        end
      end
      S_UPDATE: state_d = S_LOAD;
      S_DENSE: begin
        acc_d = acc_sum;
        j_d   = j_q + 5'd1;
        if (j_q == 5'd31) state_d = S_VALID;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Read data is built from pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    data_out_d = data_out_q;
    if (read && addr_ok) begin
      case (addr[2:0])
        3'd0:    data_out_d = {30'd0, valid, busy};
        3'd7:    data_out_d = {{16{result_q[15]}}, result_q};
        default: data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      data_out_q <= '0;
      dense_b_q  <= '0;
      result_q   <= '0;
      for (int n = 0; n < 4; n++)    x_q[n] <= '0;
      for (int n = 0; n < 128; n++)  w_q[n] <= '0;
      for (int n = 0; n < 1024; n++) r_q[n] <= '0;
      for (int n = 0; n < 32; n++) begin
        b_q[n]  <= '0;
        d_q[n]  <= '0;
        h_q[n]  <= '0;
        hn_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      j_q        <= j_d;
      data_out_q <= data_out_d;
      if (wr_ok) begin
        case (addr[2:0])
          3'd0: if (data_in[1]) for (int n = 0; n < 32; n++) h_q[n] <= '0;
          3'd1: if (idx < 16'd4) x_q[idx[1:0]] <= wval;
          3'd2: if (row < 8'd4 && col < 8'd32) w_q[{row[1:0], col[4:0]}] <= wval;
          3'd3: if (row < 8'd32 && col < 8'd32) r_q[{row[4:0], col[4:0]}] <= wval;
          3'd4: if (idx < 16'd32) b_q[idx[4:0]] <= wval;
          3'd5: if (idx < 16'd32) d_q[idx[4:0]] <= wval;
          3'd6: dense_b_q <= wval;
          default: ;
        endcase
      end
      if (state_q == S_MAC && i_q == 6'd35) hn_q[j_q] <= act(sat16(acc_sum, b_q[j_q]));
      // hn is committed in one shot so every column of the step saw the old h.
      if (state_q == S_UPDATE) for (int n = 0; n < 32; n++) h_q[n] <= hn_q[n];
      if (state_q == S_DENSE && j_q == 5'd31) result_q <= sat16(acc_sum, dense_b_q);
    end
  end

endmodule

// File: tb/tb_rnn_accel.sv
// Bench for rnn_accel: directed steps plus randomized parameters checked against an arithmetic model.
module tb_rnn_accel;

  logic        clk;
  logic        rst_n;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int mx [4];
  int mw [4][32];
  int mr [32][32];
  int mb [32];
  int md [32];
  int mdb;
  int mh [32];
  int mres;

  rnn_accel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int act(int z);
`ifdef RNN_HARDTANH_EN
    if (z > 256)  return 256;
    if (z < -256) return -256;
`endif
    return z;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0;
      for (int j = 0; j < 32; j++) mw[i][j] = 0;
    end
    for (int k = 0; k < 32; k++) begin
      mb[k] = 0; md[k] = 0; mh[k] = 0;
      for (int j = 0; j < 32; j++) mr[k][j] = 0;
    end
    mdb = 0;
    mres = 0;
  endtask

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d);
    int idx, rw, cl, val;
    logic [15:0] lo;
    idx = int'(d[31:16]);
    rw  = int'(d[31:24]);
    cl  = int'(d[23:16]);
    lo  = d[15:0];
    val = int'($signed(lo));
    case (a)
      1: if (idx < 4)  mx[idx] = val;
      2: if (rw < 4 && cl < 32)  mw[rw][cl] = val;
      3: if (rw < 32 && cl < 32) mr[rw][cl] = val;
      4: if (idx < 32) mb[idx] = val;
      5: if (idx < 32) md[idx] = val;
      6: mdb = val;
      default: ;
    endcase
  endtask

  task automatic mstep(bit clr);
    longint acc;
    int hn [32];
    if (clr) for (int k = 0; k < 32; k++) mh[k] = 0;
    for (int j = 0; j < 32; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++)  acc += longint'(mx[i]) * mw[i][j];
      for (int k = 0; k < 32; k++) acc += longint'(mh[k]) * mr[k][j];
      hn[j] = act(sat16((acc >>> 8) + mb[j]));
    end
    mh = hn;
  endtask

  task automatic mdense();
    longint acc;
    acc = 0;
    for (int k = 0; k < 32; k++) acc += longint'(mh[k]) * md[k];
    mres = sat16((acc >>> 8) + mdb);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every bus task starts at a negedge and consumes exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    write = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic wrm(input logic [31:0] a, input logic [31:0] d);
    wr(a, d);
    mwrite(a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0; addr = '0;
    v = data_out;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_stat(logic [31:0] want, int maxn, string tag);
    logic [31:0] v;
    int n = 0;
    rd(0, v);
    while (v !== want && n < maxn) begin
      rd(0, v);
      n++;
    end
    chk(tag, v, want);
  endtask

  function automatic logic [15:0] rnd(int m);
    int t;
    t = int'($urandom_range(2 * m)) - m;
    return t[15:0];
  endfunction

  task automatic run_step(bit clr);
    wr(0, clr ? 32'd2 : 32'd0);
    wait_stat(0, 1300, "step_done");
    mstep(clr);
  endtask

  // Reads h[k] through the dense path; needs D all zero and dense_b zero.
  task automatic probe(int k, logic [31:0] exp, string tag);
    logic [31:0] v;
    wrm(5, {16'(k), 16'd256});
    wr(7, 0);
    wait_stat(2, 64, "probe_valid");
    rd(7, v);
    chk(tag, v, exp);
    wrm(5, {16'(k), 16'd0});
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    mreset();
    idle(3);
    rst_n = 1'b1;

    rd(0, v); chk("rst_status", v, 32'd0);
    rd(7, v); chk("rst_result", v, 32'd0);
    rd(5, v); chk("rst_other_addr", v, 32'd0);

    wrm(1, {16'd2, 16'h0080});
    wrm(2, {8'd3, 8'd31, 16'hFF00});
    rd(0, v); chk("status_load", v, 32'd0);

    wrm(4, {16'd40, 16'h1234});
    wrm(2, {8'd4, 8'd0, 16'h1234});
    wrm(6, 32'd5);
    wr(32'h0000_0106, 32'd77);
    wr(7, 0);
    wait_stat(2, 64, "dense0_valid");
    rd(7, v); chk("dense_b_only", v, 32'd5);

    // x[2]=0x80 against W[2][31]=256 and x[3]=256 against W[3][31]=-256 gives h[31] = -128
    wrm(6, 32'd0);
    wrm(1, {16'd3, 16'd256});
    wrm(2, {8'd2, 8'd31, 16'd256});
    run_step(1'b1);
    probe(31, 32'hFFFF_FF80, "h31_xw_loaded");

    wrm(1, {16'd0, 16'd256});
    for (int i = 1; i < 4; i++) wrm(1, {16'(i), 16'd0});
    for (int j = 0; j < 32; j++) wrm(2, {8'd0, 8'(j), 16'd256});
    for (int j = 0; j < 32; j++) wrm(4, {16'(j), 16'hFFFE});
    wr(0, 32'd2);
    idle(10);
    rd(0, v); chk("busy_mid_step", v, 32'd1);
    idle(1142);
    rd(0, v); chk("busy_in_update", v, 32'd1);
    rd(0, v); chk("load_at_1154", v, 32'd0);
    mstep(1'b1);
    probe(5, 32'd254, "h5_254");
    probe(31, 32'd254, "h31_254");

    wrm(2, {8'd0, 8'd0, 16'd1024});
    for (int j = 0; j < 32; j++) wrm(4, {16'(j), 16'd0});
    run_step(1'b1);
`ifdef RNN_HARDTANH_EN
    probe(0, 32'd256, "h0_hardtanh");
`else
    probe(0, 32'd1024, "h0_linear");
`endif
    probe(1, 32'd256, "h1_256");

    wrm(2, {8'd0, 8'd0, 16'd256});
    run_step(1'b1);
    for (int k = 0; k < 32; k++) wrm(5, {16'(k), 16'd1});
    wrm(6, 32'd5);
    wr(7, 0);
    idle(31);
    rd(0, v); chk("dense_busy_31", v, 32'd1);
    rd(0, v); chk("dense_valid_32", v, 32'd2);
    rd(7, v); chk("dense_37", v, 32'd37);
    rd(32'h0000_0107, v); chk("upper_addr_hold", v, 32'd37);
    idle(2);
    chk("hold_no_read", data_out, 32'd37);
    read = 1'b1; write = 1'b1; addr = 32'd0; data_in = 32'd0;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chk("read_pre_write", data_out, 32'd2);
    wait_stat(0, 1300, "rw_step_done");
    mstep(1'b0);

    for (int k = 0; k < 32; k++) wrm(5, {16'(k), 16'h7FFF});
    wr(7, 0);
    wait_stat(2, 64, "sat_pos_valid");
    rd(7, v); chk("sat_pos", v, 32'h0000_7FFF);
    for (int k = 0; k < 32; k++) wrm(5, {16'(k), 16'h8000});
    wr(7, 0);
    wait_stat(2, 64, "sat_neg_valid");
    rd(7, v); chk("sat_neg", v, 32'hFFFF_8000);
    for (int k = 0; k < 32; k++) wrm(5, {16'(k), 16'd0});
    wrm(6, 32'd0);

    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 4; i++) wrm(1, {16'(i), rnd(1000)});
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 32; j++) wrm(2, {8'(i), 8'(j), rnd(300)});
      for (int k = 0; k < 32; k++)
        for (int j = 0; j < 32; j++) wrm(3, {8'(k), 8'(j), rnd(100)});
      for (int j = 0; j < 32; j++) wrm(4, {16'(j), rnd(2000)});
      wr(0, (it == 0) ? 32'd2 : 32'd0);
      idle(50);
      wr(3, {8'd0, 8'd0, 16'h7FFF});
      wr(4, {16'd0, 16'h4000});
      wr(7, 0);
      wr(0, 32'd2);
      wait_stat(0, 1300, "rand_step_done");
      mstep(it == 0);
      for (int k = 0; k < 32; k++) probe(k, mh[k], $sformatf("rand%0d_h%0d", it, k));
    end

    for (int k = 0; k < 32; k++) wrm(5, {16'(k), rnd(300)});
    wrm(6, {16'd0, rnd(2000)});
    wr(7, 0);
    wait_stat(2, 64, "rand_dense_valid");
    mdense();
    rd(7, v); chk("rand_dense", v, mres);

    wr(0, 32'd2);
    idle(100);
    wr(3, {8'd0, 8'd0, 16'h1234});
    idle(20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
    rd(0, v); chk("abort_status", v, 32'd0);
    rd(7, v); chk("abort_result", v, 32'd0);
    wrm(1, {16'd0, 16'd256});
    wrm(2, {8'd0, 8'd0, 16'd256});
    run_step(1'b1);
    probe(0, 32'd256, "post_reset_h0");
    probe(1, 32'd0, "post_reset_h1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
